// File: rtl/mcdt_arbiter_if.sv
// rtl/mcdt_arbiter_if.sv - slave FIFO and formatter signal bundle for mcdt_arbiter
// master is the arbiter's view; slave is the view of the FIFOs and formatter around it.
interface mcdt_arbiter_if #(
  parameter int DW = 32
);
  logic          slv0_req_i;
  logic          slv1_req_i;
  logic          slv2_req_i;
  logic          slv0_val_i;
  logic          slv1_val_i;
  logic          slv2_val_i;
  logic [DW-1:0] slv0_data_i;
  logic [DW-1:0] slv1_data_i;
  logic [DW-1:0] slv2_data_i;
  logic          a2s0_ack_o;
  logic          a2s1_ack_o;
  logic          a2s2_ack_o;
  logic          f2a_ready_i;
  logic          a2f_val_o;
  logic [DW-1:0] a2f_data_o;
  logic [1:0]    a2f_id_o;
  logic          a2f_busy_o;

  modport master (
    input  slv0_req_i, slv1_req_i, slv2_req_i,
    input  slv0_val_i, slv1_val_i, slv2_val_i,
    input  slv0_data_i, slv1_data_i, slv2_data_i,
    input  f2a_ready_i,
    output a2s0_ack_o, a2s1_ack_o, a2s2_ack_o,
    output a2f_val_o, a2f_data_o, a2f_id_o, a2f_busy_o
  );

  modport slave (
    output slv0_req_i, slv1_req_i, slv2_req_i,
    output slv0_val_i, slv1_val_i, slv2_val_i,
    output slv0_data_i, slv1_data_i, slv2_data_i,
    output f2a_ready_i,
    input  a2s0_ack_o, a2s1_ack_o, a2s2_ack_o,
    input  a2f_val_o, a2f_data_o, a2f_id_o, a2f_busy_o
  );
endinterface

// File: rtl/mcdt_arbiter.sv
// rtl/mcdt_arbiter.sv - three-channel priority/round-robin burst arbiter toward the packet formatter
// Optional WAIT timeout with sticky err_o is enabled by defining MCDT_ARB_TIMEOUT_EN.
module mcdt_arbiter #(
  parameter int DW        = 32,
  parameter int BURST_LEN = 4
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic [2:0]     cfg_en_i,
  input  logic [5:0]     cfg_prio_i,
  mcdt_arbiter_if.master bus
`ifdef MCDT_ARB_TIMEOUT_EN
  ,
  output logic           err_o
`endif
);

  typedef enum logic [1:0] {IDLE, ACK, WAIT, OUT} state_t;

  localparam logic [3:0] BURST_MAX = 4'(BURST_LEN);

  state_t        state, state_nxt;
  logic [1:0]    win, win_nxt;
  logic [1:0]    last, last_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic          val_q, val_nxt;
  logic [DW-1:0] data_q, data_nxt;
  logic [1:0]    id_q, id_nxt;

  logic [2:0]    req;
  logic [2:0]    val;
  logic [2:0]    elig;
  logic [DW-1:0] slv_data [3];
  logic [1:0]    pick;
  logic          found;

`ifdef MCDT_ARB_TIMEOUT_EN
  logic [2:0]    to_cnt, to_nxt;
  logic          err_q, err_nxt;
`endif

  assign req         = {bus.slv2_req_i, bus.slv1_req_i, bus.slv0_req_i};
  assign val         = {bus.slv2_val_i, bus.slv1_val_i, bus.slv0_val_i};
  assign slv_data[0] = bus.slv0_data_i;
  assign slv_data[1] = bus.slv1_data_i;
  assign slv_data[2] = bus.slv2_data_i;
  assign elig        = req & cfg_en_i;

  // Scan channels starting just after the last grant; strict '<' keeps the
  // first channel in round-robin order among those sharing the best priority.
  always_comb begin
    logic [2:0] idx;
    logic [1:0] ch;
    logic [1:0] p;
    logic [1:0] best;
    found = 1'b0;
    pick  = 2'd0;
    best  = 2'd3;
    idx   = 3'd0;
    ch    = 2'd0;
    p     = 2'd0;
    for (int k = 1; k <= 3; k++) begin
      idx = {1'b0, last} + 3'(k);
      if (idx >= 3'd3) idx = idx - 3'd3;
      ch = idx[1:0];
      p  = cfg_prio_i[{ch, 1'b0} +: 2];
      if (elig[ch] && (!found || p < best)) begin
        found = 1'b1;
        pick  = ch;
        best  = p;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state  <= IDLE;
      win    <= 2'd0;
      last   <= 2'd2;
      cnt    <= 4'd0;
      val_q  <= 1'b0;
      data_q <= '0;
      id_q   <= 2'd0;
`ifdef MCDT_ARB_TIMEOUT_EN
      to_cnt <= 3'd0;
      err_q  <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      win    <= win_nxt;
      last   <= last_nxt;
      cnt    <= cnt_nxt;
      val_q  <= val_nxt;
      data_q <= data_nxt;
      id_q   <= id_nxt;
`ifdef MCDT_ARB_TIMEOUT_EN
      to_cnt <= to_nxt;
      err_q  <= err_nxt;
`endif
    end
  end

  // Configuration is only consulted while IDLE, so reprogramming mid-burst
  // takes effect at the next arbitration.
  always_comb begin
    state_nxt = state;
    win_nxt   = win;
    last_nxt  = last;
    cnt_nxt   = cnt;
    val_nxt   = val_q;
    data_nxt  = data_q;
    id_nxt    = id_q;
`ifdef MCDT_ARB_TIMEOUT_EN
    to_nxt    = to_cnt;
    err_nxt   = err_q;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          win_nxt   = pick;
          cnt_nxt   = 4'd0;
          state_nxt = ACK;
        end
      end
      ACK: begin
`ifdef MCDT_ARB_TIMEOUT_EN
        to_nxt    = 3'd0;
`endif
        state_nxt = WAIT;
      end
      WAIT: begin
        if (val[win]) begin
          data_nxt  = slv_data[win];
          id_nxt    = win;
          val_nxt   = 1'b1;
          state_nxt = OUT;
        end
`ifdef MCDT_ARB_TIMEOUT_EN
        else if (to_cnt == 3'd3) begin
          last_nxt  = win;
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          to_nxt    = to_cnt + 3'd1;
        end
`endif
      end
      OUT: begin
        if (val_q && bus.f2a_ready_i) begin
          val_nxt = 1'b0;
          cnt_nxt = cnt + 4'd1;
          if (cnt_nxt < BURST_MAX && req[win]) begin
            state_nxt = ACK;
          end else begin
            last_nxt  = win;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.a2s0_ack_o = (state == ACK) && (win == 2'd0);
  assign bus.a2s1_ack_o = (state == ACK) && (win == 2'd1);
  assign bus.a2s2_ack_o = (state == ACK) && (win == 2'd2);
  assign bus.a2f_val_o  = val_q;
  assign bus.a2f_data_o = data_q;
  assign bus.a2f_id_o   = id_q;
  assign bus.a2f_busy_o = (state != IDLE);

`ifdef MCDT_ARB_TIMEOUT_EN
  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_mcdt_arbiter.sv
// tb/tb_mcdt_arbiter.sv - directed vector bench for mcdt_arbiter
// Arbitration table plus hand-written burst, backpressure, reset and timeout sequences.
module tb_mcdt_arbiter;
  localparam int DW = 32;
  localparam int BL = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic [2:0] cfg_en;
  logic [5:0] cfg_prio;
`ifdef MCDT_ARB_TIMEOUT_EN
  logic       err;
  logic       err_s;
`endif

  mcdt_arbiter_if #(.DW(DW)) bus ();

  mcdt_arbiter #(.DW(DW), .BURST_LEN(BL)) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .cfg_en_i   (cfg_en),
    .cfg_prio_i (cfg_prio),
    .bus        (bus)
`ifdef MCDT_ARB_TIMEOUT_EN
    ,
    .err_o      (err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] en;
    logic [5:0] prio;
    logic [2:0] req;
    logic       grant;
    logic [1:0] id;
  } arb_vec_t;

  arb_vec_t    tbl [11];
  int          nvec = 0;
  int          nerr = 0;
  int          cyc  = 0;
  logic [31:0] fq0[$], fq1[$], fq2[$];
  logic [2:0]  ack_s;
  logic        val_s, busy_s, withhold;
  logic [31:0] data_s;
  logic [1:0]  id_s;
  int          nacks, last_ack_cyc;
  int          nack_ch [3];
  logic [1:0]  acc_id[$];
  logic [31:0] acc_data[$];
  int          acc_cyc[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] gen(input int ch, input int i);
    return 32'hC000_0000 | (32'(ch) << 16) | 32'(i);
  endfunction

  function automatic logic [31:0] fpop(input int ch);
    logic [31:0] w;
    w = 32'hDEAD_BEEF;
    case (ch)
      0: if (fq0.size() > 0) w = fq0.pop_front();
      1: if (fq1.size() > 0) w = fq1.pop_front();
      default: if (fq2.size() > 0) w = fq2.pop_front();
    endcase
    return w;
  endfunction

  task automatic update_req();
    bus.slv0_req_i = (fq0.size() > 0);
    bus.slv1_req_i = (fq1.size() > 0);
    bus.slv2_req_i = (fq2.size() > 0);
  endtask

  task automatic push(input int ch, input logic [31:0] w);
    case (ch)
      0: fq0.push_back(w);
      1: fq1.push_back(w);
      default: fq2.push_back(w);
    endcase
    update_req();
  endtask

  // Sample outputs mid-cycle, then act as the FIFOs: an ack seen this cycle
  // pops a word that is presented with val during the following cycle.
  task automatic tick();
    logic [31:0] w;
    @(negedge clk);
    cyc++;
    ack_s  = {bus.a2s2_ack_o, bus.a2s1_ack_o, bus.a2s0_ack_o};
    val_s  = bus.a2f_val_o;
    data_s = bus.a2f_data_o;
    id_s   = bus.a2f_id_o;
    busy_s = bus.a2f_busy_o;
`ifdef MCDT_ARB_TIMEOUT_EN
    err_s  = err;
`endif
    chk("ack_onehot", 32'($countones(ack_s) > 1), 32'd0);
    chk("ack_while_val", 32'((ack_s != 3'b000) && val_s), 32'd0);
    if (ack_s != 3'b000) begin
      nacks++;
      last_ack_cyc = cyc;
      for (int c = 0; c < 3; c++) if (ack_s[c]) nack_ch[c]++;
    end
    if (val_s && bus.f2a_ready_i) begin
      acc_id.push_back(id_s);
      acc_data.push_back(data_s);
      acc_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    bus.slv0_val_i = 1'b0;
    bus.slv1_val_i = 1'b0;
    bus.slv2_val_i = 1'b0;
    if (ack_s[0]) begin w = fpop(0); bus.slv0_val_i = !withhold; bus.slv0_data_i = w; end
    if (ack_s[1]) begin w = fpop(1); bus.slv1_val_i = !withhold; bus.slv1_data_i = w; end
    if (ack_s[2]) begin w = fpop(2); bus.slv2_val_i = !withhold; bus.slv2_data_i = w; end
    update_req();
  endtask

  task automatic clear_log();
    acc_id.delete();
    acc_data.delete();
    acc_cyc.delete();
    nacks = 0;
    for (int c = 0; c < 3; c++) nack_ch[c] = 0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    fq0.delete();
    fq1.delete();
    fq2.delete();
    bus.slv0_val_i = 1'b0;
    bus.slv1_val_i = 1'b0;
    bus.slv2_val_i = 1'b0;
    withhold = 1'b0;
    update_req();
    clear_log();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic run_until(input int n, input int budget, input string name);
    for (int i = 0; i < budget && acc_id.size() < n; i++) tick();
    chk(name, 32'(acc_id.size()), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0, a0, r0;
    int ridx [3];
    logic [31:0] d0;
    logic [1:0]  i0;

    rstn = 1'b0;
    cfg_en = 3'b111;
    cfg_prio = 6'b000000;
    withhold = 1'b0;
    bus.f2a_ready_i = 1'b1;
    bus.slv0_data_i = '0;
    bus.slv1_data_i = '0;
    bus.slv2_data_i = '0;
    bus.slv0_val_i = 1'b0;
    bus.slv1_val_i = 1'b0;
    bus.slv2_val_i = 1'b0;
    update_req();
    clear_log();

    // reset outputs, before any clock edge
    #1;
    chk("rst_acks", 32'({bus.a2s2_ack_o, bus.a2s1_ack_o, bus.a2s0_ack_o}), 32'd0);
    chk("rst_val", 32'(bus.a2f_val_o), 32'd0);
    chk("rst_data", bus.a2f_data_o, 32'd0);
    chk("rst_id", 32'(bus.a2f_id_o), 32'd0);
    chk("rst_busy", 32'(bus.a2f_busy_o), 32'd0);
`ifdef MCDT_ARB_TIMEOUT_EN
    chk("rst_err", 32'(err), 32'd0);
`endif

    // arbitration table: {en, prio(ch2,ch1,ch0), req, grant, id}, pointer=2 after reset
    tbl[0]  = '{3'b111, 6'b000000, 3'b111, 1'b1, 2'd0};
    tbl[1]  = '{3'b111, 6'b001111, 3'b111, 1'b1, 2'd2};
    tbl[2]  = '{3'b011, 6'b001111, 3'b111, 1'b1, 2'd0};
    tbl[3]  = '{3'b011, 6'b000000, 3'b100, 1'b0, 2'd0};
    tbl[4]  = '{3'b111, 6'b100110, 3'b111, 1'b1, 2'd1};
    tbl[5]  = '{3'b101, 6'b000000, 3'b110, 1'b1, 2'd2};
    tbl[6]  = '{3'b000, 6'b000000, 3'b111, 1'b0, 2'd0};
    tbl[7]  = '{3'b110, 6'b010100, 3'b111, 1'b1, 2'd1};
    tbl[8]  = '{3'b111, 6'b111111, 3'b101, 1'b1, 2'd0};
    tbl[9]  = '{3'b111, 6'b110100, 3'b110, 1'b1, 2'd1};
    tbl[10] = '{3'b111, 6'b000110, 3'b011, 1'b1, 2'd1};

    for (int v = 0; v < 11; v++) begin
      do_reset();
      cfg_en = tbl[v].en;
      cfg_prio = tbl[v].prio;
      bus.f2a_ready_i = 1'b1;
      for (int c = 0; c < 3; c++) if (tbl[v].req[c]) push(c, gen(c, 0));
      repeat (6) tick();
      chk($sformatf("arb%0d_grant", v), 32'(acc_id.size()), 32'(tbl[v].grant));
      if (tbl[v].grant && acc_id.size() > 0) begin
        chk($sformatf("arb%0d_id", v), 32'(acc_id[0]), 32'(tbl[v].id));
        chk($sformatf("arb%0d_data", v), acc_data[0], gen(int'(tbl[v].id), 0));
      end else begin
        chk($sformatf("arb%0d_noack", v), 32'(nacks), 32'd0);
      end
    end

    // basic pop with latency: req in N, ack in N+1, output valid in N+3
    do_reset();
    cfg_en = 3'b111;
    cfg_prio = 6'b000000;
    push(1, 32'hA5A5_0001);
    n0 = cyc + 1;
    repeat (8) tick();
    chk("basic_nacks", 32'(nack_ch[1]), 32'd1);
    chk("basic_ack_cyc", 32'(last_ack_cyc), 32'(n0 + 1));
    chk("basic_count", 32'(acc_id.size()), 32'd1);
    if (acc_id.size() > 0) begin
      chk("basic_val_cyc", 32'(acc_cyc[0]), 32'(n0 + 3));
      chk("basic_data", acc_data[0], 32'hA5A5_0001);
      chk("basic_id", 32'(acc_id[0]), 32'd1);
    end
    chk("basic_idle", 32'(busy_s), 32'd0);

    // round-robin among equal priorities, 4-word bursts
    do_reset();
    for (int c = 0; c < 3; c++) begin
      ridx[c] = 0;
      for (int i = 0; i < 8; i++) push(c, gen(c, i));
    end
    run_until(24, 200, "rr_count");
    for (int k = 0; k < 24 && k < acc_id.size(); k++) begin
      chk($sformatf("rr_id%0d", k), 32'(acc_id[k]), 32'((k / 4) % 3));
      chk($sformatf("rr_data%0d", k), acc_data[k], gen(int'(acc_id[k]), ridx[acc_id[k]]));
      ridx[acc_id[k]]++;
    end
    if (acc_cyc.size() >= 5) begin
      chk("rr_burst_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
      chk("rr_rearb_gap", 32'(acc_cyc[4] - acc_cyc[3]), 32'd4);
    end

    // static priority: ch2 drained first, then round-robin resumes at ch0
    do_reset();
    cfg_prio = 6'b001111;
    for (int c = 0; c < 3; c++) for (int i = 0; i < 5; i++) push(c, gen(c, i));
    run_until(6, 80, "prio_count");
    for (int k = 0; k < 6 && k < acc_id.size(); k++)
      chk($sformatf("prio_id%0d", k), 32'(acc_id[k]), (k < 5) ? 32'd2 : 32'd0);

    // disabled channel never acked
    do_reset();
    cfg_en = 3'b011;
    cfg_prio = 6'b000000;
    for (int i = 0; i < 3; i++) push(2, gen(2, i));
    for (int i = 0; i < 2; i++) push(1, gen(1, i));
    repeat (30) tick();
    chk("dis_ch2_acks", 32'(nack_ch[2]), 32'd0);
    chk("dis_ch1_words", 32'(acc_id.size()), 32'd2);
    chk("dis_idle", 32'(busy_s), 32'd0);
    cfg_en = 3'b111;

    // backpressure: output held stable for 10 cycles, next ack 1 cycle after accept
    do_reset();
    bus.f2a_ready_i = 1'b0;
    push(0, gen(0, 0));
    push(0, gen(0, 1));
    for (int i = 0; i < 10 && !val_s; i++) tick();
    chk("bp_val_seen", 32'(val_s), 32'd1);
    d0 = data_s;
    i0 = id_s;
    a0 = nacks;
    chk("bp_data0", d0, gen(0, 0));
    repeat (10) begin
      tick();
      chk("bp_val_hold", 32'(val_s), 32'd1);
      chk("bp_data_hold", data_s, d0);
      chk("bp_id_hold", 32'(id_s), 32'(i0));
    end
    chk("bp_no_ack", 32'(nacks), 32'(a0));
    bus.f2a_ready_i = 1'b1;
    tick();
    chk("bp_accept", 32'(acc_id.size()), 32'd1);
    r0 = cyc;
    repeat (2) tick();
    chk("bp_next_ack", 32'(last_ack_cyc), 32'(r0 + 1));

    // short burst: two words then back to IDLE
    do_reset();
    push(1, gen(1, 0));
    push(1, gen(1, 1));
    repeat (15) tick();
    chk("short_count", 32'(acc_id.size()), 32'd2);
    chk("short_acks", 32'(nacks), 32'd2);
    chk("short_idle", 32'(busy_s), 32'd0);

    // reset during WAIT: outputs clear at once and the pointer returns to 2
    do_reset();
    push(0, gen(0, 0));
    repeat (8) tick();
    push(1, gen(1, 0));
    push(1, gen(1, 1));
    push(1, gen(1, 2));
    for (int i = 0; i < 8 && !ack_s[1]; i++) tick();
    chk("rstw_ack_seen", 32'(ack_s[1]), 32'd1);
    rstn = 1'b0;
    #1;
    chk("rstw_acks", 32'({bus.a2s2_ack_o, bus.a2s1_ack_o, bus.a2s0_ack_o}), 32'd0);
    chk("rstw_val", 32'(bus.a2f_val_o), 32'd0);
    chk("rstw_busy", 32'(bus.a2f_busy_o), 32'd0);
    bus.slv1_val_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    clear_log();
    push(0, gen(0, 1));
    run_until(1, 10, "rstw_count");
    if (acc_id.size() > 0) chk("rstw_ptr_id", 32'(acc_id[0]), 32'd0);

`ifdef MCDT_ARB_TIMEOUT_EN
    // timeout: val withheld, IDLE after 4 WAIT cycles, err sticky until reset
    do_reset();
    withhold = 1'b1;
    push(0, gen(0, 0));
    for (int i = 0; i < 6 && !ack_s[0]; i++) tick();
    chk("to_ack_seen", 32'(ack_s[0]), 32'd1);
    repeat (4) begin
      tick();
      chk("to_wait_busy", 32'(busy_s), 32'd1);
      chk("to_err_low", 32'(err_s), 32'd0);
    end
    tick();
    chk("to_idle", 32'(busy_s), 32'd0);
    chk("to_err_set", 32'(err_s), 32'd1);
    repeat (5) tick();
    chk("to_err_sticky", 32'(err_s), 32'd1);
    chk("to_no_val", 32'(acc_id.size()), 32'd0);
    do_reset();
    chk("to_err_cleared", 32'(err), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mcdt_arbiter.md
Name: mcdt_arbiter

Overview:
- Three-channel arbiter that sits between the per-channel slave FIFOs and the downstream packet formatter.
- Selects one requesting FIFO using configurable static priority, with round-robin among equal priorities.
- Pops up to BURST_LEN words from the selected FIFO with single-cycle acks and registers each word to the formatter under a valid/ready handshake.
- Configuration comes from the register block.

Parameters:
- DW, 32, data width of slave and formatter data paths.
- BURST_LEN, 4, maximum words popped per grant (legal range 1..15).

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  asynchronous, active-low reset.
- slv0_req_i / slv1_req_i / slv2_req_i  in  1 each  FIFO non-empty request.
- slv0_val_i / slv1_val_i / slv2_val_i  in  1 each  popped data valid; arrives 1 cycle after ack.
- slv0_data_i / slv1_data_i / slv2_data_i  in  DW each  popped data.
- a2s0_ack_o / a2s1_ack_o / a2s2_ack_o  out  1 each  pop strobe to the FIFO.
- cfg_en_i  in  3  per-channel enable.
- cfg_prio_i  in  6  2 bits per channel; ch n uses [2n+1:2n]; 0 is highest priority.
- f2a_ready_i  in  1  formatter ready.
- a2f_val_o  out  1  output word valid.
- a2f_data_o  out  DW  output word.
- a2f_id_o  out  2  source channel of the output word.
- a2f_busy_o  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, immediate): all acks 0, a2f_val_o 0, a2f_data_o 0, a2f_id_o 0, a2f_busy_o 0, FSM to IDLE, burst counter 0, last-grant pointer 2 (so ch0 wins the first round-robin tie). Reset mid-burst abandons the burst; a word already popped from a FIFO is lost.
- FSM states: IDLE, ACK, WAIT, OUT.
- IDLE:
  - Eligible channels are those with req=1 and en=1.
  - If none are eligible, stay in IDLE.
  - Otherwise compute the winner: lowest prio value; ties go to the first eligible channel after the last-grant pointer, in order 0→1→2→0.
  - Latch the winner, cfg_prio_i and cfg_en_i (cfg is sampled only here), set the burst counter to 0, go to ACK.
- ACK: drive a2sN_ack_o=1 for the winner only, for exactly one cycle; go to WAIT.
- WAIT: on slvN_val_i of the winner, register slvN_data_i into a2f_data_o and the winner into a2f_id_o, set a2f_val_o=1, go to OUT.
- OUT:
  - Hold a2f_val_o, a2f_data_o and a2f_id_o stable while f2a_ready_i=0.
  - On a cycle with a2f_val_o=1 and f2a_ready_i=1, the word is accepted: a2f_val_o clears the next cycle and the burst counter increments.
  - After acceptance: if the new count < BURST_LEN and the winner's req is still 1, go to ACK (back-to-back pop; no re-arbitration).
  - Otherwise update the last-grant pointer to the winner and go to IDLE.
- Latency: req seen in cycle N → ack in N+1 → slave val in N+2 → a2f_val_o in N+3. With f2a_ready_i held at 1, a burst sustains 1 word per 3 cycles.
- Only one ack may ever be high at a time, and never while a2f_val_o is pending.
- A req from a channel with en=0 is ignored. Disabling the winner mid-burst takes effect at the next IDLE.
- If all enabled channels have equal priority, pure round-robin results.

Optional Feature:
- Macro: MCDT_ARB_TIMEOUT_EN.
- When defined:
  - A 3-bit counter runs in WAIT.
  - If no val arrives within 4 cycles after the ack, the FSM returns to IDLE, the last-grant pointer updates to the winner, and sticky output err_o (1 bit, reset 0) is set.
  - err_o is cleared only by reset.
- When not defined: no err_o port and no counter; WAIT holds indefinitely until val arrives.

Test Plan:
- Basic pop: ch1 only, en=3'b111, prio all 0, ch1 FIFO holds 1 word 32'hA5A5_0001, ready=1 → a2s1_ack_o one pulse at N+1; a2f_val_o=1 at N+3 with data A5A5_0001, id=1; return to IDLE.
- Round-robin: all three FIFOs hold 8 words, equal prio, BURST_LEN=4, ready=1 → id sequence 0,0,0,0,1,1,1,1,2,2,2,2,0…; one ack at a time.
- Priority/enable: prio ch2=0, ch0=ch1=3, all requesting → ch2 drained first. Then en=3'b011 with ch2 requesting → ch2 never acked.
- Backpressure: hold f2a_ready_i=0 for 10 cycles during OUT → data/id stable, no new ack; word accepted the cycle ready rises; next ack follows 1 cycle later.
- Short burst and reset: FIFO with 2 words, BURST_LEN=4 → 2 words then IDLE (req dropped). Assert rstn_i low in WAIT → acks and a2f_val_o 0 immediately, FSM in IDLE, pointer=2.
- Timeout (with MCDT_ARB_TIMEOUT_EN): ack issued, slave val withheld → after 4 cycles FSM returns to IDLE and err_o=1 until reset.
